// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and constants for the gshare branch predictor.
// These are the predictor additions to the LC-3b type set:
//   lc3b_word    - 16-bit machine word (PCs)
//   bp_entry_t   - in-flight checkpoint {PHT index, prediction, spec history}
//   BP_CTR_INIT  - reset value of a PHT counter (weakly not-taken)
// The BP_* widths size bp_entry_t and must track the IDX_BITS / GHR_BITS /
// CTR_BITS parameters of the gshare_branch_predictor instance.
package gshare_branch_predictor_pkg;

    typedef logic [15:0] lc3b_word;

    localparam int BP_IDX_BITS = 5;
    localparam int BP_GHR_BITS = 5;
    localparam int BP_CTR_BITS = 2;

    // Weakly not-taken: MSB clear, every lower bit set (01 for 2-bit).
    function automatic int ctr_init(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    localparam int BP_CTR_INIT = ctr_init(BP_CTR_BITS);

    typedef struct packed {
        logic [BP_IDX_BITS-1:0] idx;
        logic                   pred;
        logic [BP_GHR_BITS-1:0] ghr;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular queue holding one checkpoint per unresolved branch.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push, push_data - enqueue at tail (ignored when full)
//   pop         - dequeue head (ignored when empty)
//   clear       - synchronous discard of all entries; wins over push/pop
//   head_data   - oldest entry (undefined contents when empty)
//   count, full, empty - occupancy
// Pointers wrap modulo DEPTH, which must be a power of two.
module bp_inflight_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem[head_ptr];

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare conditional-branch predictor with in-flight checkpoint queue.
// Predicts at IF (combinational), checkpoints {idx, pred, ghr_spec} per
// accepted fetch, resolves oldest-first at WB, trains the PHT on resolve and
// restores speculative history on mispredict or flush.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (highest priority)
//   fetch_pc          - PC in IF
//   fetch_valid       - IF holds a conditional branch and advances
//   predict_taken     - prediction for fetch_pc
//   resolve_valid     - oldest in-flight branch resolves this cycle
//   resolve_taken     - its actual direction
//   resolve_pred      - stored prediction of the oldest entry (0 when empty)
//   mispredict        - resolve disagrees with its stored prediction
//   flush             - non-branch redirect; discards all in-flight entries
//   inflight_count, full, empty - queue occupancy
//   stat_branches, stat_mispredicts - saturating 16-bit statistics
// Build option: define PREDICTOR_STATS_EN to build the statistics counters;
// otherwise both statistics outputs are tied to zero.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int IDX_BITS       = BP_IDX_BITS,
    parameter int CTR_BITS       = BP_CTR_BITS,
    parameter int GHR_BITS       = BP_GHR_BITS,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  lc3b_word                            fetch_pc,
    input  logic                                fetch_valid,
    output logic                                predict_taken,
    input  logic                                resolve_valid,
    input  logic                                resolve_taken,
    output logic                                resolve_pred,
    output logic                                mispredict,
    input  logic                                flush,
    output logic [$clog2(INFLIGHT_DEPTH+1)-1:0] inflight_count,
    output logic                                full,
    output logic                                empty,
    output logic [15:0]                         stat_branches,
    output logic [15:0]                         stat_mispredicts
);

    localparam int                 PHT_SIZE = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] pht [PHT_SIZE];
    logic [GHR_BITS-1:0] ghr_spec;
    logic [GHR_BITS-1:0] ghr_commit;
    logic [GHR_BITS-1:0] ghr_commit_next;
    logic [GHR_BITS-1:0] head_ghr;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] head_idx;
    logic [CTR_BITS-1:0] head_ctr;
    logic                resolve_fire;
    logic                fetch_accept;
    logic                queue_clear;
    bp_entry_t           push_entry;
    bp_entry_t           head;
    logic                unused_pc_bits;

    // PC bit 0 is always zero (word-aligned), upper bits fall outside the PHT.
    assign unused_pc_bits = ^{fetch_pc[15:IDX_BITS+1], fetch_pc[0]};

    assign idx           = fetch_pc[IDX_BITS:1] ^ IDX_BITS'(ghr_spec);
    assign predict_taken = pht[idx][CTR_BITS-1];

    assign resolve_fire  = resolve_valid & ~empty;
    assign resolve_pred  = ~empty & head.pred;
    assign mispredict    = resolve_fire & (resolve_taken != head.pred);
    assign fetch_accept  = fetch_valid & ~full & ~flush & ~mispredict;
    // A mispredict makes every younger entry wrong-path.
    assign queue_clear   = mispredict | flush;

    assign head_idx = IDX_BITS'(head.idx);
    assign head_ghr = GHR_BITS'(head.ghr);
    assign head_ctr = pht[head_idx];

    always_comb begin
        push_entry      = '0;
        push_entry.idx  = BP_IDX_BITS'(idx);
        push_entry.pred = predict_taken;
        push_entry.ghr  = BP_GHR_BITS'(ghr_spec);
    end

    // Committed history after this cycle's resolve; a flush copies it so a
    // same-cycle correct resolve is already included.
    assign ghr_commit_next = resolve_fire ? {ghr_commit[GHR_BITS-2:0], resolve_taken}
                                          : ghr_commit;

    bp_inflight_fifo #(
        .WIDTH ($bits(bp_entry_t)),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch_accept),
        .push_data (push_entry),
        .pop       (resolve_fire),
        .clear     (queue_clear),
        .head_data (head),
        .count     (inflight_count),
        .full      (full),
        .empty     (empty)
    );

    // PHT training: saturating up/down on the resolving branch's counter.
    // No read bypass: a same-cycle prediction sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (resolve_fire) begin
            if (resolve_taken && head_ctr != CTR_MAX) begin
                pht[head_idx] <= head_ctr + CTR_BITS'(1);
            end else if (!resolve_taken && head_ctr != '0) begin
                pht[head_idx] <= head_ctr - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
        end else begin
            ghr_commit <= ghr_commit_next;
            // Mispredict recovery rebuilds history from the checkpoint; it
            // matches the flush rule when both occur.
            if (mispredict) begin
                ghr_spec <= {head_ghr[GHR_BITS-2:0], resolve_taken};
            end else if (flush) begin
                ghr_spec <= ghr_commit_next;
            end else if (fetch_accept) begin
                ghr_spec <= {ghr_spec[GHR_BITS-2:0], predict_taken};
            end
        end
    end

`ifdef PREDICTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve_fire && stat_branches != 16'hFFFF) begin
                stat_branches <= stat_branches + 16'd1;
            end
            if (mispredict && stat_mispredicts != 16'hFFFF) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: a hand-derived vector
// table for reset/training/saturation, directed multi-cycle sequences for
// mispredict, full, concurrent fetch+resolve and flush, then random traffic.
// Every cycle is also checked against a queue-based reference model.
module tb_gshare_branch_predictor;

    localparam int IDX_BITS = 5;
    localparam int GHR_BITS = 5;
    localparam int DEPTH    = 4;
    localparam int IDX_MASK = (1 << IDX_BITS) - 1;
    localparam int GHR_MASK = (1 << GHR_BITS) - 1;
    localparam int CTR_MAX  = 3;

    logic        clk;
    logic        reset;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        predict_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_pred;
    logic        mispredict;
    logic        flush;
    logic [2:0]  inflight_count;
    logic        full;
    logic        empty;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    gshare_branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .predict_taken    (predict_taken),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_pred     (resolve_pred),
        .mispredict       (mispredict),
        .flush            (flush),
        .inflight_count   (inflight_count),
        .full             (full),
        .empty            (empty),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        bit pred;
        int ghr;
    } m_entry_t;

    m_entry_t mq[$];
    int pht_m[1 << IDX_BITS];
    int spec_m, commit_m, sb_m, sm_m;
    int m_idx;
    bit m_pred, m_rfire, m_mp, m_rpred;

    task automatic model_reset();
        foreach (pht_m[i]) pht_m[i] = 1;
        spec_m = 0; commit_m = 0; sb_m = 0; sm_m = 0;
        mq.delete();
    endtask

    task automatic model_eval();
        m_idx   = ((int'(fetch_pc) >> 1) & IDX_MASK) ^ spec_m;
        m_pred  = (pht_m[m_idx] >= 2);
        m_rfire = resolve_valid && (mq.size() > 0);
        m_rpred = (mq.size() > 0) ? mq[0].pred : 1'b0;
        m_mp    = m_rfire && (resolve_taken != m_rpred);
    endtask

    task automatic model_update();
        m_entry_t h;
        bit accept;
        accept = fetch_valid && (mq.size() < DEPTH) && !flush && !m_mp;
        if (m_rfire) begin
            h = mq.pop_front();
            if (resolve_taken && pht_m[h.idx] < CTR_MAX) pht_m[h.idx]++;
            if (!resolve_taken && pht_m[h.idx] > 0) pht_m[h.idx]--;
            commit_m = ((commit_m << 1) | int'(resolve_taken)) & GHR_MASK;
            if (sb_m < 16'hFFFF) sb_m++;
            if (m_mp && sm_m < 16'hFFFF) sm_m++;
        end
        if (m_mp) begin
            mq.delete();
            spec_m = ((h.ghr << 1) | int'(resolve_taken)) & GHR_MASK;
        end else if (flush) begin
            mq.delete();
            spec_m = commit_m;
        end else if (accept) begin
            mq.push_back('{idx: m_idx, pred: m_pred, ghr: spec_m});
            spec_m = ((spec_m << 1) | int'(m_pred)) & GHR_MASK;
        end
    endtask

    task automatic model_check();
        int exp_sb, exp_sm;
`ifdef PREDICTOR_STATS_EN
        exp_sb = sb_m; exp_sm = sm_m;
`else
        exp_sb = 0; exp_sm = 0;
`endif
        check("m_predict_taken", predict_taken, m_pred);
        check("m_mispredict", mispredict, m_mp);
        check("m_resolve_pred", resolve_pred, m_rpred);
        check("m_inflight_count", inflight_count, mq.size());
        check("m_full", full, mq.size() == DEPTH);
        check("m_empty", empty, mq.size() == 0);
        check("m_stat_branches", stat_branches, exp_sb);
        check("m_stat_mispredicts", stat_mispredicts, exp_sm);
    endtask

    // ---------------- driver tasks ----------------
    // apply: drive at negedge, compare outputs 1 time unit later.
    task automatic apply(input logic fv, input logic [15:0] pc, input logic rv,
                         input logic rt, input logic fl);
        @(negedge clk);
        fetch_valid = fv; fetch_pc = pc; resolve_valid = rv;
        resolve_taken = rt; flush = fl;
        #1;
        model_eval();
        model_check();
    endtask

    // advance: commit the cycle in the model, then let the DUT clock.
    task automatic advance();
        model_update();
        @(posedge clk);
    endtask

    task automatic cycle(input logic fv, input logic [15:0] pc, input logic rv,
                         input logic rt, input logic fl);
        apply(fv, pc, rv, rt, fl);
        advance();
    endtask

    task automatic do_reset(input bit noisy);
        @(negedge clk);
        reset = 1'b1;
        fetch_valid   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        fetch_pc      = 16'($urandom);
        resolve_valid = noisy;
        resolve_taken = 1'($urandom_range(0, 1));
        flush         = noisy;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fetch_valid = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] rand_pc();
        return 16'($urandom) & 16'hFFFE;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        fv;
        logic [15:0] pc;
        logic        rv;
        logic        rt;
        logic        fl;
        logic        e_pred;
        logic        e_mp;
        logic        e_rpred;
        int          e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fv, input logic [15:0] pc, input logic rv, input logic rt,
                       input logic e_pred, input logic e_mp, input logic e_rpred, input int e_cnt);
        vq.push_back('{fv: fv, pc: pc, rv: rv, rt: rt, fl: 1'b0,
                       e_pred: e_pred, e_mp: e_mp, e_rpred: e_rpred, e_cnt: e_cnt});
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;

        // Reset state, weak not-taken, resolve while empty ignored.
        add(0, 16'h0040, 0, 0, 0, 0, 0, 0);
        add(0, 16'h1234, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0040, 1, 1, 0, 0, 0, 0);
        // Walk history up to 5'b11111 via taken mispredicts at pc 0.
        for (int k = 0; k < 5; k++) begin
            add(1, 16'h0000, 0, 0, 0, 0, 0, 0);
            add(0, 16'h0000, 1, 1, 0, 1, 0, 1);
        end
        // idx 31: train up, saturate high.
        add(1, 16'h0040, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0040, 1, 1, 0, 1, 0, 1);
        add(1, 16'h0040, 0, 0, 1, 0, 0, 0);
        add(0, 16'h0040, 1, 1, 1, 0, 1, 1);
        add(1, 16'h0040, 0, 0, 1, 0, 0, 0);
        add(0, 16'h0040, 1, 1, 1, 0, 1, 1);
        add(1, 16'h0040, 0, 0, 1, 0, 0, 0);
        // idx 31: three not-taken 11->10->01->00, pcs chosen to keep idx 31.
        add(0, 16'h0040, 1, 0, 1, 1, 1, 1);
        add(1, 16'h0042, 0, 0, 1, 0, 0, 0);
        add(0, 16'h0042, 1, 0, 0, 1, 1, 1);
        add(1, 16'h0006, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0006, 1, 0, 0, 0, 0, 1);
        // Counter at 00: a further not-taken must not wrap.
        add(1, 16'h000E, 0, 0, 0, 0, 0, 0);
        add(0, 16'h000E, 1, 0, 0, 0, 0, 1);
        add(0, 16'h001E, 0, 0, 0, 0, 0, 0);

        do_reset(1'b0);
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].fv, vq[i].pc, vq[i].rv, vq[i].rt, vq[i].fl);
            check($sformatf("vec%0d_predict", i), predict_taken, vq[i].e_pred);
            check($sformatf("vec%0d_mispredict", i), mispredict, vq[i].e_mp);
            check($sformatf("vec%0d_resolve_pred", i), resolve_pred, vq[i].e_rpred);
            check($sformatf("vec%0d_count", i), inflight_count, vq[i].e_cnt);
            advance();
        end

        // Mispredict on oldest of 3 clears queue and recovers history.
        for (int i = 0; i < 3; i++) cycle(1, rand_pc(), 0, 0, 0);
        apply(1, rand_pc(), 1, ~mq[0].pred, 0);
        check("s3_mispredict", mispredict, 1);
        advance();
        apply(0, rand_pc(), 0, 0, 0);
        check("s3_count_after", inflight_count, 0);
        advance();
        for (int i = 0; i < 4; i++) cycle(0, rand_pc(), 0, 0, 0);

        // Fill to full; a 5th fetch is ignored.
        for (int i = 0; i < 4; i++) cycle(1, rand_pc(), 0, 0, 0);
        apply(1, rand_pc(), 0, 0, 0);
        check("s4_full", full, 1);
        check("s4_count", inflight_count, 4);
        advance();
        apply(0, rand_pc(), 0, 0, 0);
        check("s4_count_after_5th", inflight_count, 4);
        advance();
        for (int i = 0; i < 4; i++) cycle(0, rand_pc(), 1, mq[0].pred, 0);

        // Concurrent fetch + correct resolve keeps count and order.
        for (int i = 0; i < 2; i++) cycle(1, rand_pc(), 0, 0, 0);
        cycle(1, rand_pc(), 1, mq[0].pred, 0);
        apply(0, rand_pc(), 0, 0, 0);
        check("s5_count", inflight_count, 2);
        advance();
        for (int i = 0; i < 2; i++) cycle(0, rand_pc(), 1, mq[0].pred, 0);

        // Flush with 2 in flight, then flush+correct resolve, flush+mispredict.
        for (int i = 0; i < 2; i++) cycle(1, rand_pc(), 0, 0, 0);
        cycle(0, rand_pc(), 0, 0, 1);
        apply(0, rand_pc(), 0, 0, 0);
        check("s6_empty", empty, 1);
        advance();
        for (int i = 0; i < 4; i++) cycle(0, rand_pc(), 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, rand_pc(), 0, 0, 0);
        cycle(1, rand_pc(), 1, mq[0].pred, 1);
        for (int i = 0; i < 4; i++) cycle(0, rand_pc(), 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, rand_pc(), 0, 0, 0);
        cycle(1, rand_pc(), 1, ~mq[0].pred, 1);
        for (int i = 0; i < 4; i++) cycle(0, rand_pc(), 0, 0, 0);

        // Reset mid-operation with resolve and flush asserted.
        for (int i = 0; i < 3; i++) cycle(1, rand_pc(), 0, 0, 0);
        do_reset(1'b1);
        apply(0, 16'h0040, 0, 0, 0);
        check("rst_empty", empty, 1);
        check("rst_predict", predict_taken, 0);
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), rand_pc(),
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
